// File: rtl/agntd_seq_pkg.sv
// Shared definitions for the agntd_seq programmable step sequencer:
// FSM state encoding and the default period width / program depth.
package agntd_seq_pkg;

  localparam int AGNTD_W     = 11;
  localparam int AGNTD_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/agntd_seq_cnt.sv
// W-bit loadable down-counter that stops at zero; clear beats load beats
// decrement, and zero flags the terminal value.
module agntd_seq_cnt #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] ld_val,
  input  logic         ce,
  output logic [W-1:0] q,
  output logic         zero
);

  logic [W-1:0] q_r;

  // Count register: clear, reload or saturating decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= {W{1'b0}};
    end else if (clr) begin
      q_r <= {W{1'b0}};
    end else if (load) begin
      q_r <= ld_val;
    end else if (ce && (q_r != {W{1'b0}})) begin
      q_r <= q_r - W'(1);
    end else begin
      q_r <= q_r;
    end
  end

  assign q    = q_r;
  assign zero = (q_r == {W{1'b0}});

endmodule

// File: rtl/agntd_seq.sv
// Programmable multi-step period sequencer: DEPTH period slots run in order,
// one down-count per slot. Optional repeat mode built with AGNTD_SEQ_LOOP_EN.
module agntd_seq
  import agntd_seq_pkg::*;
#(
  parameter  int W     = AGNTD_W,
  parameter  int DEPTH = AGNTD_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW:0]   nsteps,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  output logic [W-1:0]  q,
  output logic          tc,
  output logic [AW-1:0] step_idx,
  output logic          busy,
  output logic          done
);

  state_t        state_r, state_nxt_s;
  logic [W-1:0]  slot_r [DEPTH];
  logic [AW:0]   nsteps_r;
  logic [AW-1:0] step_r, step_nxt_s, step_inc_s, ld_idx_s;
  logic [W-1:0]  q_s, ld_val_s;
  logic          cnt_ld_s, cnt_clr_s, ns_ld_s, start_ok_s, last_s;
  logic          zero_s, tc_s, wrap_s, busy_r, done_r;

  // A programmed period of 0 still lasts one ce, so it reloads like 1.
  function automatic logic [W-1:0] ld_of(input logic [W-1:0] p);
    return (p == {W{1'b0}}) ? {W{1'b0}} : (p - W'(1));
  endfunction

`ifdef AGNTD_SEQ_LOOP_EN
  assign wrap_s = loop;
`else
  logic loop_unused_s;
  assign loop_unused_s = loop;
  assign wrap_s        = 1'b0;
`endif

  assign start_ok_s = start && !stop && (nsteps != {(AW+1){1'b0}}) &&
                      (nsteps <= (AW+1)'(DEPTH));
  assign last_s     = ({1'b0, step_r} == (nsteps_r - (AW+1)'(1)));
  assign step_inc_s = step_r + AW'(1);
  assign tc_s       = (state_r == ST_RUN) && ce && zero_s;
  // Slot read is the pre-edge value, so a coincident write loads the old period.
  assign ld_val_s   = ld_of(slot_r[ld_idx_s]);

  // Next-state, step and counter-control decode.
  always_comb begin
    state_nxt_s = state_r;
    step_nxt_s  = step_r;
    ld_idx_s    = {AW{1'b0}};
    cnt_ld_s    = 1'b0;
    cnt_clr_s   = 1'b0;
    ns_ld_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) begin
          state_nxt_s = ST_RUN;
          step_nxt_s  = {AW{1'b0}};
          cnt_ld_s    = 1'b1;
          ns_ld_s     = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_nxt_s = ST_IDLE;
          step_nxt_s  = {AW{1'b0}};
          cnt_clr_s   = 1'b1;
        end else if (tc_s && !last_s) begin
          step_nxt_s = step_inc_s;
          ld_idx_s   = step_inc_s;
          cnt_ld_s   = 1'b1;
        end else if (tc_s && wrap_s) begin
          step_nxt_s = {AW{1'b0}};
          cnt_ld_s   = 1'b1;
        end else if (tc_s) begin
          state_nxt_s = ST_DONE;
          step_nxt_s  = {AW{1'b0}};
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        step_nxt_s  = {AW{1'b0}};
        cnt_clr_s   = 1'b1;
      end
    endcase
  end

  // FSM, step index, sampled step count and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      step_r   <= {AW{1'b0}};
      nsteps_r <= {(AW+1){1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      step_r   <= step_nxt_s;
      nsteps_r <= ns_ld_s ? nsteps : nsteps_r;
      busy_r   <= (state_nxt_s == ST_RUN);
      done_r   <= (state_nxt_s == ST_DONE);
    end
  end

  // Program slots, writable in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) slot_r[i] <= {W{1'b0}};
    end else if (wr_en) begin
      slot_r[wr_addr] <= wr_data;
    end
  end

  agntd_seq_cnt #(.W(W)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr_s),
    .load   (cnt_ld_s),
    .ld_val (ld_val_s),
    .ce     (ce && (state_r == ST_RUN)),
    .q      (q_s),
    .zero   (zero_s)
  );

  assign q        = q_s;
  assign tc       = tc_s;
  assign step_idx = step_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule
